itof_pipe: RTL and testbench

ITOF_PIPE -- requirements
Module: itof_pipe

---
 rtl/fpu_pkg.sv | 30 +++
 rtl/itof_pipe_lzc.sv | 25 ++
 rtl/itof_pipe.sv | 147 ++++++++++++++
 tb/tb_itof_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared floating-point definitions for the integer-to-float pipeline.
//   FLOAT_BIAS / MANT_W / EXP_W : IEEE-754 binary32 field parameters
//   float32_t                   : packed {sign, exp, mant} view of a binary32
//   float_pack()                : assembles a float32_t from its fields
// -----------------------------------------------------------------------------
package fpu_pkg;

  localparam int unsigned FLOAT_BIAS = 127;
  localparam int unsigned MANT_W     = 23;
  localparam int unsigned EXP_W      = 8;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } float32_t;

  function automatic float32_t float_pack(input logic              sign,
                                          input logic [EXP_W-1:0]  exp,
                                          input logic [MANT_W-1:0] mant);
    float32_t f;
    f.sign = sign;
    f.exp  = exp;
    f.mant = mant;
    return f;
  endfunction

endpackage

// File: rtl/itof_pipe_lzc.sv
// -----------------------------------------------------------------------------
// lzc
// Combinational leading-zero counter.
//   data_i : operand, W bits
//   cnt_o  : number of leading zeros, $clog2(W)+1 bits; all-zero input gives W
// -----------------------------------------------------------------------------
module lzc #(
  parameter  int unsigned W  = 32,
  localparam int unsigned CW = $clog2(W) + 1
) (
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] cnt_o
);

  // Scanning upward lets the highest set bit make the final assignment.
  always_comb begin
    cnt_o = CW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (data_i[i]) begin
        cnt_o = CW'(W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/itof_pipe.sv
// -----------------------------------------------------------------------------
// itof_pipe
// Pipelined integer (signed or unsigned) to IEEE-754 binary32 converter with
// valid/ready handshakes and a single global stall enable.
//   clk, rstn          : clock, asynchronous active-low reset
//   in_valid/in_ready  : input handshake (in_ready = pipeline enable)
//   in_data, in_signed : IW-bit operand and its signedness
//   out_valid/out_ready: output handshake
//   out_data           : binary32 result
//   out_inexact        : rounding discarded nonzero bits
// The accepted word is registered first, then passes three processing stages
// (sign/magnitude, normalise, round/pack), so a result emerges three edges
// after its acceptance edge.
// -----------------------------------------------------------------------------
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned IW     = 32,
  parameter int unsigned NSTAGE = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_data,
  input  logic          in_signed,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          out_inexact
);

  generate
    if (NSTAGE != 3) begin : g_bad_nstage
      $error("itof_pipe: NSTAGE must be 3");
    end
    if (IW < 2 || IW > 32) begin : g_bad_iw
      $error("itof_pipe: IW must be in 2..32");
    end
  endgenerate

  logic en;

  // Input capture register
  logic          s0_valid_q;
  logic [IW-1:0] s0_data_q;
  logic          s0_signed_q;

  // Stage 1: sign and magnitude
  logic          s1_valid_q;
  logic          s1_sign_q,  s1_sign_d;
  logic [31:0]   s1_mag_q,   s1_mag_d;
  logic [IW-1:0] s1_neg;

  // Stage 2: normalisation
  logic          s2_valid_q;
  logic          s2_sign_q;
  logic [31:0]   s2_norm_q,  s2_norm_d;
  logic [5:0]    s2_lz_q,    s2_lz_d;

  // Stage 3: round and pack (output register)
  logic          out_valid_q;
  float32_t      out_data_q, out_data_d;
  logic          out_inexact_q, out_inexact_d;

  logic [MANT_W-1:0] mant;
  logic [MANT_W:0]   mant_inc;
  logic              guard, sticky, round_up, carry;
  logic [EXP_W-1:0]  exp_v;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // ---------------- stage 1 ----------------
  always_comb begin
    s1_sign_d = s0_signed_q && s0_data_q[IW-1];
    s1_neg    = ~s0_data_q + IW'(1);
    s1_mag_d  = '0;
    s1_mag_d[IW-1:0] = s1_sign_d ? s1_neg : s0_data_q;
  end

  // ---------------- stage 2 ----------------
  lzc #(.W(32)) u_lzc (
    .data_i (s1_mag_q),
    .cnt_o  (s2_lz_d)
  );

  assign s2_norm_d = s1_mag_q << s2_lz_d;

  // ---------------- stage 3 ----------------
  // A clear bit 31 after normalisation means the magnitude was zero.
  always_comb begin
    mant     = s2_norm_q[30:8];
    guard    = s2_norm_q[7];
    sticky   = |s2_norm_q[6:0];
    round_up = guard && (sticky || mant[0]);
    mant_inc = {1'b0, mant} + (MANT_W+1)'(round_up);
    carry    = mant_inc[MANT_W];
    exp_v    = EXP_W'(FLOAT_BIAS + 31) - EXP_W'(s2_lz_q) + EXP_W'(carry);
    if (s2_norm_q[31]) begin
      // On carry the incremented mantissa field is already all zeros.
      out_data_d    = float_pack(s2_sign_q, exp_v, mant_inc[MANT_W-1:0]);
      out_inexact_d = guard || sticky;
    end else begin
      out_data_d    = '0;
      out_inexact_d = 1'b0;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0_valid_q    <= 1'b0;
      s0_data_q     <= '0;
      s0_signed_q   <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_mag_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_norm_q     <= '0;
      s2_lz_q       <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_inexact_q <= 1'b0;
    end else if (en) begin
      s0_valid_q    <= in_valid;
      s0_data_q     <= in_data;
      s0_signed_q   <= in_signed;
      s1_valid_q    <= s0_valid_q;
      s1_sign_q     <= s1_sign_d;
      s1_mag_q      <= s1_mag_d;
      s2_valid_q    <= s1_valid_q;
      s2_sign_q     <= s1_sign_q;
      s2_norm_q     <= s2_norm_d;
      s2_lz_q       <= s2_lz_d;
      out_valid_q   <= s2_valid_q;
      out_data_q    <= out_data_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_itof_pipe.sv
// -----------------------------------------------------------------------------
// tb_itof_pipe
// Directed bench for itof_pipe: an IW=32 instance for conversion, latency,
// backpressure and reset behaviour, and an IW=16 instance for narrow operands.
// -----------------------------------------------------------------------------
module tb_itof_pipe;

  logic        clk;
  logic        rstn;

  logic        in_valid, in_ready, in_signed;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_inexact;
  logic [31:0] out_data;

  logic        in16_valid, in16_ready, in16_signed;
  logic [15:0] in16_data;
  logic        out16_valid, out16_ready, out16_inexact;
  logic [31:0] out16_data;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  itof_pipe #(.IW(32), .NSTAGE(3)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_signed   (in_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_inexact (out_inexact)
  );

  itof_pipe #(.IW(16), .NSTAGE(3)) dut16 (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in16_valid),
    .in_ready    (in16_ready),
    .in_data     (in16_data),
    .in_signed   (in16_signed),
    .out_valid   (out16_valid),
    .out_ready   (out16_ready),
    .out_data    (out16_data),
    .out_inexact (out16_inexact)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference conversion in real arithmetic, rounding to nearest-even.
  // Returns {inexact, binary32 bits}.
  function automatic logic [32:0] ref_conv(input logic [31:0] d, input bit s);
    bit     neg;
    longint m, f;
    real    r, p, sc, fr;
    int     e, k;
    bit     inx;
    neg = s && d[31];
    m = neg ? -longint'($signed(d)) : longint'({32'b0, d});
    if (m == 0) return 33'b0;
    r = real'(m);
    e = 0;
    p = 1.0;
    while (r >= 2.0 * p) begin
      p = p * 2.0;
      e++;
    end
    sc = r;
    k  = e;
    while (k > 23) begin sc = sc / 2.0; k--; end
    while (k < 23) begin sc = sc * 2.0; k++; end
    f   = longint'($rtoi(sc));
    fr  = sc - real'(f);
    inx = (fr != 0.0);
    if (fr > 0.5 || (fr == 0.5 && f[0])) f++;
    if (f == 64'd16777216) begin
      f = 64'd8388608;
      e++;
    end
    return {inx, neg, 8'(e + 127), f[22:0]};
  endfunction

  // One isolated word: checks acceptance, exact 3-edge latency and result.
  task automatic run_one(input bit w16, input logic [31:0] d, input bit s,
                         input logic [31:0] exp_d, input bit exp_i, input string tag);
    if (w16) begin
      in16_valid = 1'b1; in16_data = d[15:0]; in16_signed = s;
    end else begin
      in_valid = 1'b1; in_data = d; in_signed = s;
    end
    #1;
    check({tag, "_rdy"}, w16 ? in16_ready : in_ready, 1);
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in16_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k == 3) check({tag, "_vld"}, w16 ? out16_valid : out_valid, 1);
      else        check({tag, "_lat"}, w16 ? out16_valid : out_valid, 0);
    end
    check({tag, "_data"}, w16 ? out16_data : out_data, exp_d);
    check({tag, "_inx"},  w16 ? out16_inexact : out_inexact, exp_i);
    @(posedge clk); #1;
  endtask

  // Back-to-back stream with a 5-cycle out_ready stall.
  task automatic stream_test();
    logic [32:0] exp_q[$];
    logic [31:0] words[20];
    bit          sgns[20];
    int unsigned sent = 0, got = 0, cyc = 0;
    logic [31:0] prev_d = '0;
    logic        prev_i = 1'b0;
    bit          prev_stall = 0;
    for (int i = 0; i < 20; i++) begin
      words[i] = $urandom;
      if (i % 4 == 1) words[i] = words[i] >> $urandom_range(4, 28);
      sgns[i] = 1'($urandom_range(0, 1));
    end
    while (got < 20 && cyc < 200) begin
      if (prev_stall) begin
        check("bp_hold_vld",  out_valid, 1);
        check("bp_hold_data", out_data, prev_d);
        check("bp_hold_inx",  out_inexact, prev_i);
      end
      out_ready = !(cyc >= 8 && cyc < 13);
      if (sent < 20) begin
        in_valid = 1'b1; in_data = words[sent]; in_signed = sgns[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 8 && cyc < 13) begin
        check("bp_stall_vld", out_valid, 1);
        check("bp_stall_rdy", in_ready, 0);
      end else begin
        check("bp_rdy", in_ready, !(out_valid && !out_ready));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_conv(words[sent], sgns[sent]));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("bp_spurious", 1, 0);
        else check("bp_data", {out_inexact, out_data}, exp_q.pop_front());
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_i     = out_inexact;
      @(posedge clk); #1;
      cyc++;
    end
    check("bp_count", got, 20);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    in_valid = 1'b0; in_data = '0; in_signed = 1'b0; out_ready = 1'b1;
    in16_valid = 1'b0; in16_data = '0; in16_signed = 1'b0; out16_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_vld",  out_valid, 0);
    check("reset_data", out_data, 0);
    check("reset_inx",  out_inexact, 0);
    check("reset_rdy",  in_ready, 1);
    rstn = 1'b1;

    run_one(0, 32'h0000_0000, 1, 32'h0000_0000, 0, "s_zero");
    run_one(0, 32'hFFFF_FFFF, 1, 32'hBF80_0000, 0, "s_m1");
    run_one(0, 32'h8000_0000, 1, 32'hCF00_0000, 0, "s_min");
    run_one(0, 32'h0000_0001, 1, 32'h3F80_0000, 0, "s_one");
    run_one(0, 32'h0000_0000, 0, 32'h0000_0000, 0, "u_zero");
    run_one(0, 32'h8000_0000, 0, 32'h4F00_0000, 0, "u_msb");
    run_one(0, 32'hFFFF_FFFF, 0, 32'h4F80_0000, 1, "u_max");
    run_one(0, 32'h0100_0001, 1, 32'h4B80_0000, 1, "tie_even");
    run_one(0, 32'h0100_0003, 1, 32'h4B80_0002, 1, "tie_odd");
    run_one(0, 32'h00FF_FFFF, 1, 32'h4B7F_FFFF, 0, "exact24");

    stream_test();

    // Reset with three words in flight (first already at the output).
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h0000_1000 << i; in_signed = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_vld", out_valid, 1);
    rstn = 1'b0;
    #1;
    check("rst_vld",  out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_rdy",  in_ready, 1);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("rst_stale", out_valid, 0);
    end
    run_one(0, 32'hFFFF_FF9C, 1, 32'hC2C8_0000, 0, "post_rst");

    run_one(1, 32'h0000_8000, 1, 32'hC700_0000, 0, "w16_min");
    run_one(1, 32'h0000_FFFF, 0, 32'h477F_FF00, 0, "w16_umax");
    run_one(1, 32'h0000_FFFF, 1, 32'hBF80_0000, 0, "w16_m1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
